uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four single-byte holding registers shared by requesters,
// granted round-robin to one UART transmit engine. The engine handshake is
// tx_rdy high -> load pulse -> tx_rdy low (busy) -> tx_rdy high (finished),
// after which the granted requester receives a one-cycle done pulse.
module uart_tx_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_wr,
  input  logic [31:0] req_data,
  output logic [3:0]  req_busy,
  output logic [3:0]  ovf,
  input  logic        tx_rdy,
  output logic        tx_load,
  output logic [7:0]  tx_data,
  output logic [1:0]  tx_src,
  output logic [3:0]  done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;

  // Per-requester holding registers and status
  logic [3:0][7:0] hold_q, hold_d;
  logic [3:0]      busy_q, busy_d;
  logic [3:0]      ovf_q,  ovf_d;

  // Round-robin pointer: index of the last requester that completed
  logic [1:0]      ptr_q,  ptr_d;

  // Registered engine-side outputs
  logic            load_q, load_d;
  logic [7:0]      data_q, data_d;
  logic [1:0]      src_q,  src_d;
  logic [3:0]      done_q, done_d;

  // Round-robin search result
  logic            grant_vld;
  logic [1:0]      grant_idx;
  logic [1:0]      cand;

  // Set while the granted holding register is being handed to the engine
  logic            release_slot;

  // Pick the first full holding register starting one past the pointer
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k < 32'd5; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_vld && busy_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // FSM next-state and next values of the registered engine-side outputs
  always_comb begin
    state_d      = state_q;
    load_d       = 1'b0;
    done_d       = '0;
    data_d       = data_q;
    src_d        = src_q;
    ptr_d        = ptr_q;
    release_slot = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld && tx_rdy) begin
          state_d = LOAD;
          load_d  = 1'b1;
          src_d   = grant_idx;
          data_d  = hold_q[grant_idx];
        end
      end
      LOAD: begin
        release_slot = 1'b1;
        state_d      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_rdy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_rdy) begin
          state_d = IDLE;
          done_d  = 4'b0001 << src_q;
          ptr_d   = src_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding-register capture, busy flags and sticky overflow flags.
  // The granted slot stays busy through the LOAD cycle, so a write to it in
  // that cycle falls into the overflow branch rather than refilling it.
  always_comb begin
    hold_d = hold_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    if (release_slot) begin
      busy_d[src_q] = 1'b0;
    end
    for (int unsigned i = 0; i < 32'd4; i++) begin
      if (req_wr[i]) begin
        if (busy_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          busy_d[i] = 1'b1;
          hold_d[i] = req_data[8*i +: 8];
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      busy_q <= '0;
      ovf_q  <= '0;
      ptr_q  <= 2'd3;
      load_q <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
      done_q <= '0;
    end else begin
      hold_q <= hold_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      ptr_q  <= ptr_d;
      load_q <= load_d;
      data_q <= data_d;
      src_q  <= src_d;
      done_q <= done_d;
    end
  end

  assign req_busy = busy_q;
  assign ovf      = ovf_q;
  assign tx_load  = load_q;
  assign tx_data  = data_q;
  assign tx_src   = src_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_uart_tx_arbiter;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [3:0]  req_wr   = '0;
  logic [31:0] req_data = '0;
  logic        tx_rdy   = 1'b0;
  logic [3:0]  req_busy;
  logic [3:0]  ovf;
  logic [3:0]  done;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic [1:0]  tx_src;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req_wr   (req_wr),
    .req_data (req_data),
    .req_busy (req_busy),
    .ovf      (ovf),
    .tx_rdy   (tx_rdy),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_src   (tx_src),
    .done     (done)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [3:0] m_pend;          // requester has a byte waiting to be sent
  bit [3:0] m_ovf;
  bit [7:0] m_hold [4];
  int       m_last;          // requester that most recently finished
  int       m_src;
  bit [7:0] m_data;
  bit       m_xfer;          // byte handed to the engine, not yet finished
  bit       m_saw_low;       // engine has reported busy for this byte
  bit       e_load;          // expected tx_load in the current cycle
  bit [3:0] e_done;          // expected done in the current cycle

  // engine / stimulus controls
  int       eng_cnt       = 0;
  int       eng_len       = 0;  // 0: random busy time
  bit       rdy_force_low = 1'b0;
  int       stall_pct     = 0;
  bit [7:0] sent_q [$];

  function automatic int rr_pick(input int last, input bit [3:0] p);
    for (int k = 1; k <= 4; k++) begin
      if (p[(last + k) % 4]) return (last + k) % 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ovf = '0;
    for (int i = 0; i < 4; i++) m_hold[i] = 8'h00;
    m_last = 3; m_src = 0; m_data = 8'h00;
    m_xfer = 1'b0; m_saw_low = 1'b0;
    e_load = 1'b0; e_done = '0;
  endtask

  // Advance the model by one clock given this cycle's inputs.
  task automatic model_advance(input logic [3:0] wr, input logic [31:0] data, input logic rdy);
    bit [3:0] np;
    bit [3:0] nd;
    bit       nl;
    bit       free;
    np   = m_pend;
    nd   = '0;
    nl   = 1'b0;
    free = !e_load && !m_xfer;
    if (m_xfer) begin
      if (!m_saw_low) m_saw_low = !rdy;
      else if (rdy) begin
        nd[m_src] = 1'b1;
        m_xfer    = 1'b0;
        m_last    = m_src;
      end
    end
    if (e_load) begin
      np[m_src] = 1'b0;
      m_xfer    = 1'b1;
      m_saw_low = 1'b0;
    end
    if (free && rdy && m_pend != 0) begin
      m_src  = rr_pick(m_last, m_pend);
      m_data = m_hold[m_src];
      nl     = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (wr[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        else begin
          np[i]     = 1'b1;
          m_hold[i] = data[8*i +: 8];
        end
      end
    end
    m_pend = np;
    e_load = nl;
    e_done = nd;
  endtask

  // One clock: check outputs mid-cycle, run the engine model, drive inputs.
  task automatic cycle(input logic [3:0] wr, input logic [31:0] data);
    logic rdy;
    @(negedge clk);
    check_eq("busy", req_busy, m_pend);
    check_eq("ovf",  ovf,      m_ovf);
    check_eq("load", tx_load,  e_load);
    check_eq("done", done,     e_done);
    check_eq("src",  tx_src,   m_src);
    check_eq("data", tx_data,  m_data);
    if (tx_load) begin
      sent_q.push_back(tx_data);
      eng_cnt = (eng_len != 0) ? eng_len : $urandom_range(12, 2);
    end
    if (eng_cnt > 0) begin
      rdy = 1'b0;
      eng_cnt--;
    end else begin
      rdy = ($urandom_range(99, 0) >= stall_pct);
    end
    if (rdy_force_low) rdy = 1'b0;
    req_wr   = wr;
    req_data = data;
    tx_rdy   = rdy;
    model_advance(wr, data, rdy);
  endtask

  // Asynchronous reset asserted between edges; outputs checked immediately.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_busy", req_busy, 0);
    check_eq("rst_ovf",  ovf,      0);
    check_eq("rst_load", tx_load,  0);
    check_eq("rst_data", tx_data,  0);
    check_eq("rst_src",  tx_src,   0);
    check_eq("rst_done", done,     0);
    model_reset();
    eng_cnt  = 0;
    req_wr   = '0;
    req_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    tx_rdy = rdy_force_low ? 1'b0 : 1'b1;
    model_advance(req_wr, req_data, tx_rdy);
  endtask

  bit [7:0]    fair_exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
  int unsigned n_done;
  logic [3:0]  w;

  initial begin
    // Single byte, latency, and a write colliding with its own LOAD cycle
    do_reset();
    sent_q.delete();
    eng_len = 10;
    cycle(4'b0001, 32'h0000_0041);
    cycle(4'b0000, 32'h0);
    cycle(4'b0001, 32'h0000_0099);
    check_eq("lat_load", tx_load, 1);
    check_eq("lat_data", tx_data, 8'h41);
    check_eq("lat_src",  tx_src,  0);
    cycle(4'b0000, 32'h0);
    check_eq("ldwr_busy0", req_busy[0], 0);
    check_eq("ldwr_ovf0",  ovf[0],      1);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(4'b0000, 32'h0);
      if (done != 0) n_done++;
    end
    check_eq("single_done_cnt", n_done, 1);
    check_eq("single_sent", sent_q.size(), 1);
    eng_len = 0;

    // Fairness with a refill of requester 0 while 0x11 is in flight
    do_reset();
    sent_q.delete();
    cycle(4'b1111, 32'h1312_1110);
    for (int i = 0; i < 100 && sent_q.size() < 2; i++) cycle(4'b0000, 32'h0);
    cycle(4'b0001, 32'h0000_0020);
    for (int i = 0; i < 200 && sent_q.size() < 5; i++) cycle(4'b0000, 32'h0);
    repeat (20) cycle(4'b0000, 32'h0);
    check_eq("fair_n", sent_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < sent_q.size()) check_eq($sformatf("fair_%0d", i), sent_q[i], fair_exp[i]);
    end

    // Engine stalled from reset with all four registers full
    rdy_force_low = 1'b1;
    do_reset();
    sent_q.delete();
    cycle(4'b1111, 32'hD3C2_B1A0);
    repeat (20) cycle(4'b0000, 32'h0);
    check_eq("stall_busy", req_busy, 4'hF);
    check_eq("stall_sent", sent_q.size(), 0);
    rdy_force_low = 1'b0;
    for (int i = 0; i < 300 && sent_q.size() < 4; i++) cycle(4'b0000, 32'h0);
    repeat (30) cycle(4'b0000, 32'h0);
    check_eq("stall_loads", sent_q.size(), 4);

    // Overflow on requester 2 while the engine is not ready
    rdy_force_low = 1'b1;
    do_reset();
    sent_q.delete();
    cycle(4'b0100, 32'h0055_0000);
    cycle(4'b0100, 32'h00AA_0000);
    repeat (3) cycle(4'b0000, 32'h0);
    check_eq("ovf_flag", ovf, 4'b0100);
    rdy_force_low = 1'b0;
    repeat (40) cycle(4'b0000, 32'h0);
    check_eq("ovf_n", sent_q.size(), 1);
    if (sent_q.size() > 0) check_eq("ovf_byte", sent_q[0], 8'h55);
    check_eq("ovf_sticky", ovf, 4'b0100);

    // Reset while waiting for the engine to finish, two bytes still pending
    do_reset();
    sent_q.delete();
    cycle(4'b0111, 32'h0033_3231);
    for (int i = 0; i < 20 && sent_q.size() < 1; i++) cycle(4'b0000, 32'h0);
    rdy_force_low = 1'b1;
    repeat (3) cycle(4'b0000, 32'h0);
    check_eq("mid_busy", req_busy, 4'b0110);
    rdy_force_low = 1'b0;
    do_reset();
    repeat (30) cycle(4'b0000, 32'h0);
    check_eq("mid_sent", sent_q.size(), 1);

    // Randomized traffic with engine stalls and one reset in the middle
    do_reset();
    stall_pct = 10;
    for (int c = 0; c < 3000; c++) begin
      w = '0;
      for (int i = 0; i < 4; i++) if ($urandom_range(5, 0) == 0) w[i] = 1'b1;
      cycle(w, $urandom());
      if (c == 1500) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
